opb_emu_initiator: RTL and testbench
====================================

# opb_emu_initiator

Host-side counterpart of the OPB emulation target: accepts single OPB-style read/write requests from local logic and serialises each into a request message written byte-wise into the TX FIFO of the message interface. It then parses the matching response message from the RX FIFO and returns read data or a write acknowledge to the requester. A PULSE_2KHZ-based timeout guards against a silent far end. Exactly one transaction is outstanding at any time.

## Interface
- TIMEOUT_PULSES, 4, number of PULSE_2KHZ ticks without a response byte before the transaction is aborted (1..255).
- SYS_CLK  in  1  system clock; all logic on rising edge.
- SYS_RST_N  in  1  asynchronous, active-low reset.
- PULSE_2KHZ  in  1  one-SYS_CLK-wide tick at 2 kHz.
- REQ_ADDR  in  32  request address, sampled on accept.
- REQ_WDATA  in  32  write data, sampled on accept.
- REQ_RE  in  1  read request strobe.
- REQ_WE  in  1  write request strobe.
- BUSY  out  1  high from the cycle after accept until completion; strobes are ignored while high.
- RSP_RDATA  out  32  read data; valid while RSP_VALID is high, then held.
- RSP_VALID  out  1  one-cycle completion pulse for both reads and writes.
- TX_FIFO_WR  out  1  TX FIFO write strobe.
- TX_FIFO_DATA  out  8  TX byte.
- TX_FIFO_FULL  in  1  TX FIFO full.
- RX_FIFO_RD  out  1  RX FIFO read strobe.
- RX_FIFO_DATA  in  8  RX byte, valid the cycle after RX_FIFO_RD.
- RX_FIFO_EMPTY  in  1  RX FIFO empty.
- error_flag  out  1  sticky error; cleared on the next accepted request.

## Operation
- Request message: byte0 command (0x52 read, 0x57 write), bytes1-4 address MSB first. Writes add bytes5-8 data MSB first. Reads are 5 bytes; writes are 9 bytes.
- Response message: read = 0x52 followed by 4 data bytes MSB first; write = single byte 0x57.
- States:
  - IDLE -> SEND when exactly one of REQ_RE/REQ_WE is high. Latch address, data and type; clear error_flag.
  - SEND: byte counter 0..8; writes one byte per cycle while !TX_FIFO_FULL. After the last byte -> RECV.
  - RECV: issue RX_FIFO_RD when !RX_FIFO_EMPTY and no read is pending. Each returned byte is checked and shifted into RSP_RDATA. When the expected count is complete -> DONE.
  - DONE: RSP_VALID pulse for one cycle -> IDLE.
- REQ_RE and REQ_WE high together in IDLE: request not accepted; error_flag set; stays IDLE.
- Response byte0 not equal to the latched command: error_flag set; -> IDLE with no RSP_VALID. RSP_RDATA keeps its previous value.
- Timeout: a counter increments on PULSE_2KHZ in RECV and clears on every received byte. Reaching TIMEOUT_PULSES sets error_flag; -> IDLE with no RSP_VALID.
- RX bytes arriving in IDLE or SEND are drained (read only in IDLE) and discarded, and error_flag is set.
- A pending RX read at abort is completed (its byte is discarded) before IDLE.

## Timing
- Reset values: BUSY 0, RSP_RDATA 0, RSP_VALID 0, TX_FIFO_WR 0, TX_FIFO_DATA 0, RX_FIFO_RD 0, error_flag 0, state IDLE, all counters 0.
- Accept at cycle 0 (strobe sampled). BUSY and first TX_FIFO_WR at cycle 1.
- TX_FIFO_WR is never asserted while TX_FIFO_FULL is high. A stall holds the byte and counter.
- RX_FIFO_RD is at most one strobe per two cycles (read, capture).
- With the TX FIFO never full and response bytes already present: read completes RSP_VALID at cycle 16 (5 TX + 5×2 RX + 1); write at cycle 12.
- BUSY falls in the same cycle RSP_VALID rises, or the cycle after an abort. A new strobe is accepted in that cycle.
- Reset asserted mid-transaction: immediate return to reset values. A partial message in the TX FIFO is not retracted.

## Test plan
- Write 0x0000_1000 <= 0xDEAD_BEEF -> TX bytes 57 00 00 10 00 DE AD BE EF; feed RX 57 -> one RSP_VALID, error_flag 0.
- Read 0x8000_0004; feed RX 52 12 34 56 78 -> TX 52 80 00 00 04, RSP_RDATA 0x1234_5678 with RSP_VALID.
- TX_FIFO_FULL toggled every other cycle during a write -> 9 bytes in order, no write while full.
- Read with no response, TIMEOUT_PULSES=4 -> error_flag set after the 4th PULSE_2KHZ, BUSY low, no RSP_VALID; next request clears error_flag.
- Read answered with 0x57 -> error_flag set, no RSP_VALID. Also REQ_RE and REQ_WE high together -> not accepted, error_flag set.
- SYS_RST_N low after 3 TX bytes -> all outputs at reset values; a following read completes normally.

Source files
------------

// File: rtl/opb_emu_initiator.sv
// OPB emulation initiator: serialises one OPB-style read/write request into a
// byte message on the TX FIFO, then parses the matching response from the RX
// FIFO and returns read data or a write acknowledge. A timeout counted in
// PULSE_2KHZ ticks aborts a transaction whose far end stays silent.
module opb_emu_initiator #(
  parameter int unsigned TIMEOUT_PULSES = 4
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST_N,
  input  logic        PULSE_2KHZ,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic        REQ_RE,
  input  logic        REQ_WE,
  output logic        BUSY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_VALID,
  output logic        TX_FIFO_WR,
  output logic [7:0]  TX_FIFO_DATA,
  input  logic        TX_FIFO_FULL,
  output logic        RX_FIFO_RD,
  input  logic [7:0]  RX_FIFO_DATA,
  input  logic        RX_FIFO_EMPTY,
  output logic        error_flag
);

  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_PULSES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_RECV,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_wr_q, is_wr_d;
  logic        rd_pend_q, rd_pend_d;
  logic        err_q, err_d;

  logic [7:0]  cmd;
  logic [3:0]  tx_last;
  logic [7:0]  tx_byte;

  assign cmd     = is_wr_q ? CMD_WR : CMD_RD;
  assign tx_last = is_wr_q ? 4'd8 : 4'd4;

  // Select the request byte addressed by the byte counter.
  always_comb begin
    case (cnt_q)
      4'd0:    tx_byte = cmd;
      4'd1:    tx_byte = addr_q[31:24];
      4'd2:    tx_byte = addr_q[23:16];
      4'd3:    tx_byte = addr_q[15:8];
      4'd4:    tx_byte = addr_q[7:0];
      4'd5:    tx_byte = wdata_q[31:24];
      4'd6:    tx_byte = wdata_q[23:16];
      4'd7:    tx_byte = wdata_q[15:8];
      4'd8:    tx_byte = wdata_q[7:0];
      default: tx_byte = '0;
    endcase
  end

  // Next-state, datapath updates and FIFO/requester outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    is_wr_d      = is_wr_q;
    err_d        = err_q;
    BUSY         = 1'b0;
    RSP_VALID    = 1'b0;
    TX_FIFO_WR   = 1'b0;
    TX_FIFO_DATA = '0;
    RX_FIFO_RD   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        RSP_VALID = (state_q == ST_DONE);
        state_d   = ST_IDLE;
        if (REQ_RE ^ REQ_WE) begin
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          is_wr_d = REQ_WE;
          err_d   = 1'b0;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = ST_SEND;
        end else begin
          if (REQ_RE && REQ_WE) err_d = 1'b1;
          // Unsolicited bytes are drained only while truly idle.
          if (state_q == ST_IDLE && !RX_FIFO_EMPTY && !rd_pend_q) RX_FIFO_RD = 1'b1;
        end
      end

      ST_SEND: begin
        BUSY         = 1'b1;
        TX_FIFO_DATA = tx_byte;
        if (!TX_FIFO_FULL) begin
          TX_FIFO_WR = 1'b1;
          if (cnt_q == tx_last) begin
            cnt_d   = '0;
            state_d = ST_RECV;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      ST_RECV: begin
        BUSY = 1'b1;
        if (rd_pend_q) begin
          tmo_d = '0;
          if (cnt_q == 4'd0) begin
            if (RX_FIFO_DATA != cmd) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else if (is_wr_q) begin
              state_d = ST_DONE;
            end else begin
              cnt_d = 4'd1;
            end
          end else begin
            rdata_d = {rdata_q[23:0], RX_FIFO_DATA};
            if (cnt_q == 4'd4) state_d = ST_DONE;
            else               cnt_d   = cnt_q + 4'd1;
          end
        end else begin
          // The read strobe is withheld in the timeout cycle, so an abort
          // never leaves an RX read outstanding.
          if (PULSE_2KHZ) begin
            if (tmo_q == TMO_LAST) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              tmo_d = tmo_q + 8'd1;
            end
          end
          if (state_d == ST_RECV && !RX_FIFO_EMPTY) RX_FIFO_RD = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A byte read outside RECV is a stray byte: discard it and flag it.
    if (rd_pend_q && state_q != ST_RECV) err_d = 1'b1;

    rd_pend_d = RX_FIFO_RD;
  end

  // State and datapath registers.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      is_wr_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      is_wr_q   <= is_wr_d;
      rd_pend_q <= rd_pend_d;
      err_q     <= err_d;
    end
  end

  assign RSP_RDATA  = rdata_q;
  assign error_flag = err_q;

endmodule

// File: tb/tb_opb_emu_initiator.sv
// Bench for opb_emu_initiator: drives requests, models the far end with byte
// queues and checks TX bytes and completions against a scoreboard.
module tb_opb_emu_initiator;

  localparam int unsigned TP = 4;

  logic        SYS_CLK = 1'b0;
  logic        SYS_RST_N = 1'b0;
  logic        PULSE_2KHZ = 1'b0;
  logic [31:0] REQ_ADDR = '0;
  logic [31:0] REQ_WDATA = '0;
  logic        REQ_RE = 1'b0;
  logic        REQ_WE = 1'b0;
  logic        BUSY;
  logic [31:0] RSP_RDATA;
  logic        RSP_VALID;
  logic        TX_FIFO_WR;
  logic [7:0]  TX_FIFO_DATA;
  logic        TX_FIFO_FULL = 1'b0;
  logic        RX_FIFO_RD;
  logic [7:0]  RX_FIFO_DATA = '0;
  logic        RX_FIFO_EMPTY = 1'b1;
  logic        error_flag;

  opb_emu_initiator #(.TIMEOUT_PULSES(TP)) dut (
    .SYS_CLK(SYS_CLK), .SYS_RST_N(SYS_RST_N), .PULSE_2KHZ(PULSE_2KHZ),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_RE(REQ_RE), .REQ_WE(REQ_WE),
    .BUSY(BUSY), .RSP_RDATA(RSP_RDATA), .RSP_VALID(RSP_VALID),
    .TX_FIFO_WR(TX_FIFO_WR), .TX_FIFO_DATA(TX_FIFO_DATA), .TX_FIFO_FULL(TX_FIFO_FULL),
    .RX_FIFO_RD(RX_FIFO_RD), .RX_FIFO_DATA(RX_FIFO_DATA), .RX_FIFO_EMPTY(RX_FIFO_EMPTY),
    .error_flag(error_flag)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct {
    bit          abort;
    bit          wr;
    logic [31:0] rdata;
    int          acc;
    int          lat;
    int          pulses;
  } exp_t;

  exp_t        exp_rsp[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  rx_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          full_mode = 0;
  int          done_cnt = 0;
  int          pulse_cnt = 0;
  int          pdiv = 0;
  logic        prev_busy = 1'b0;
  logic [31:0] last_rdata = '0;
  exp_t        mon_e;
  int          rx_n;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  always @(posedge SYS_CLK) cyc <= cyc + 1;

  // TX FIFO back-pressure: never, alternating, or random.
  always @(posedge SYS_CLK) begin
    case (full_mode)
      0:       TX_FIFO_FULL <= 1'b0;
      1:       TX_FIFO_FULL <= ~TX_FIFO_FULL;
      default: TX_FIFO_FULL <= 1'($urandom_range(0, 1));
    endcase
  end

  // Timebase tick, one cycle wide every 7 cycles.
  always @(posedge SYS_CLK) begin
    if (pdiv == 6) begin pdiv <= 0; PULSE_2KHZ <= 1'b1; end
    else begin pdiv <= pdiv + 1; PULSE_2KHZ <= 1'b0; end
  end

  // RX FIFO model: data appears the cycle after the read strobe.
  always @(posedge SYS_CLK) begin
    rx_n = rx_q.size();
    if (RX_FIFO_RD) begin
      checks++;
      if (rx_n == 0) begin
        errors++;
        $display("FAIL rx_underflow: read strobe with empty fifo (cycle %0d)", cyc);
      end else begin
        RX_FIFO_DATA <= rx_q.pop_front();
        rx_n--;
      end
    end
    RX_FIFO_EMPTY <= (rx_n == 0);
  end

  // Monitor: TX bytes and completions, sampled mid-cycle.
  always @(negedge SYS_CLK) begin
    if (!SYS_RST_N) begin
      prev_busy = 1'b0;
      pulse_cnt = 0;
    end else begin
      if (PULSE_2KHZ && BUSY && exp_tx.size() == 0 && !TX_FIFO_WR) pulse_cnt++;
      if (TX_FIFO_WR) begin
        chk32("tx_wr_while_full", TX_FIFO_FULL, 0);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx: got %h expected no write", TX_FIFO_DATA);
        end else begin
          chk32("tx_byte", TX_FIFO_DATA, exp_tx.pop_front());
        end
      end
      if (prev_busy && !BUSY) begin
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_completion: got completion expected none");
        end else begin
          mon_e = exp_rsp.pop_front();
          chk32("rsp_valid", RSP_VALID, !mon_e.abort);
          chk32("error_flag", error_flag, mon_e.abort);
          if (!mon_e.abort && !mon_e.wr) begin
            chk32("rsp_rdata", RSP_RDATA, mon_e.rdata);
            last_rdata = mon_e.rdata;
          end else begin
            chk32("rdata_held", RSP_RDATA, last_rdata);
          end
          if (mon_e.lat >= 0)    chk32("latency", cyc - mon_e.acc, mon_e.lat);
          if (mon_e.pulses >= 0) chk32("timeout_pulses", pulse_cnt, mon_e.pulses);
        end
        pulse_cnt = 0;
        done_cnt++;
      end else if (RSP_VALID) begin
        checks++; errors++;
        $display("FAIL rsp_valid_busy: got RSP_VALID with BUSY %b expected falling BUSY", BUSY);
      end
      prev_busy = BUSY;
    end
  end

  // Push the request message the target must see.
  task automatic push_tx(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    exp_tx.push_back(wr ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(addr[8*i +: 8]);
    if (wr) for (int i = 3; i >= 0; i--) exp_tx.push_back(data[8*i +: 8]);
  endtask

  // kind: 0 good response, 1 wrong command byte, 2 silent far end.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdat, input int kind, input int mode);
    exp_t e;
    int   b;
    int   start;
    full_mode = mode;
    @(negedge SYS_CLK);
    push_tx(wr, addr, data);
    e.abort  = (kind != 0);
    e.wr     = wr;
    e.rdata  = rdat;
    e.acc    = cyc;
    e.lat    = (kind == 0 && mode == 0) ? ((wr ? 9 : 5) + 2 * (wr ? 1 : 5) + 1) : -1;
    e.pulses = (kind == 2) ? int'(TP) : -1;
    exp_rsp.push_back(e);
    start = done_cnt;
    REQ_ADDR = addr; REQ_WDATA = data; REQ_RE = !wr; REQ_WE = wr;
    b = 0;
    do begin
      @(negedge SYS_CLK); #1;
      // Strobes while busy must be ignored.
      REQ_RE = 1'($urandom_range(0, 1));
      REQ_WE = 1'($urandom_range(0, 1));
      REQ_ADDR = $urandom;
      b++;
    end while (exp_tx.size() != 0 && b < 300);
    REQ_RE = 1'b0; REQ_WE = 1'b0;
    if (exp_tx.size() != 0) begin
      checks++; errors++;
      $display("FAIL tx_timeout: got %0d bytes pending expected 0", exp_tx.size());
      finish_now();
    end
    case (kind)
      0: begin
        rx_q.push_back(wr ? 8'h57 : 8'h52);
        if (!wr) for (int i = 3; i >= 0; i--) rx_q.push_back(rdat[8*i +: 8]);
      end
      1: rx_q.push_back(wr ? 8'h52 : 8'h57);
      default: ;
    endcase
    b = 0;
    while (done_cnt == start && b < 400) begin @(negedge SYS_CLK); #1; b++; end
    if (done_cnt == start) begin
      checks++; errors++;
      $display("FAIL completion_timeout: got no completion expected one");
      finish_now();
    end
  endtask

  task automatic chk_reset_values();
    chk32("rst_busy", BUSY, 0);
    chk32("rst_rdata", RSP_RDATA, 0);
    chk32("rst_rsp_valid", RSP_VALID, 0);
    chk32("rst_tx_wr", TX_FIFO_WR, 0);
    chk32("rst_tx_data", TX_FIFO_DATA, 0);
    chk32("rst_rx_rd", RX_FIFO_RD, 0);
    chk32("rst_error", error_flag, 0);
  endtask

  initial begin
    int b;
    repeat (3) @(negedge SYS_CLK);
    chk_reset_values();
    SYS_RST_N = 1'b1;
    repeat (2) @(negedge SYS_CLK);

    do_req(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 0, 0);
    do_req(1'b0, 32'h8000_0004, 32'h0, 32'h1234_5678, 0, 0);
    do_req(1'b1, 32'hA5A5_0010, 32'h0102_0304, 32'h0, 0, 1);

    do_req(1'b0, 32'h0000_0040, 32'h0, 32'h0, 2, 0);
    do_req(1'b0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 0, 0);

    do_req(1'b0, 32'h0000_0048, 32'h0, 32'h0, 1, 2);
    do_req(1'b1, 32'h0000_004C, 32'h5555_AAAA, 32'h0, 0, 0);

    // Both strobes together: rejected with an error.
    @(negedge SYS_CLK);
    REQ_RE = 1'b1; REQ_WE = 1'b1;
    @(negedge SYS_CLK); #1;
    REQ_RE = 1'b0; REQ_WE = 1'b0;
    chk32("both_strobes_error", error_flag, 1);
    chk32("both_strobes_busy", BUSY, 0);
    repeat (2) @(negedge SYS_CLK);
    chk32("both_strobes_idle", BUSY, 0);
    do_req(1'b0, 32'h0000_0050, 32'h0, 32'h0BAD_CAFE, 0, 0);

    // Stray RX byte while idle: drained and flagged.
    @(negedge SYS_CLK); #1;
    rx_q.push_back(8'hA5);
    repeat (5) @(negedge SYS_CLK);
    chk32("stray_error", error_flag, 1);
    chk32("stray_drained", rx_q.size(), 0);
    chk32("stray_busy", BUSY, 0);
    do_req(1'b1, 32'h0000_0054, 32'h7777_8888, 32'h0, 0, 2);

    // Reset after three TX bytes of a write.
    full_mode = 0;
    @(negedge SYS_CLK);
    push_tx(1'b1, 32'h1111_2222, 32'h3333_4444);
    REQ_ADDR = 32'h1111_2222; REQ_WDATA = 32'h3333_4444; REQ_WE = 1'b1;
    b = 0;
    do begin
      @(negedge SYS_CLK); #1;
      REQ_WE = 1'b0;
      b++;
    end while (exp_tx.size() > 6 && b < 50);
    chk32("pre_reset_tx_left", exp_tx.size(), 6);
    SYS_RST_N = 1'b0;
    #1;
    chk_reset_values();
    exp_tx.delete();
    exp_rsp.delete();
    last_rdata = '0;
    repeat (2) @(negedge SYS_CLK);
    SYS_RST_N = 1'b1;
    do_req(1'b0, 32'h0000_0060, 32'h0, 32'h8765_4321, 0, 0);

    // Randomised traffic.
    for (int n = 0; n < 30; n++) begin
      do_req(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             ($urandom_range(0, 9) < 8) ? 0 : 1, int'($urandom_range(0, 2)));
    end

    repeat (5) @(negedge SYS_CLK);
    chk32("tail_tx_empty", exp_tx.size(), 0);
    chk32("tail_rsp_empty", exp_rsp.size(), 0);
    finish_now();
  end

endmodule
